// File: rtl/spi_pkg.sv
// Shared defaults and the counter-width helper for the SPI slave.
package spi_pkg;

  localparam int          DEF_WIDTH      = 8;
  localparam logic [31:0] DEF_RESET_WORD = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Bit-counter width; never below one bit so WIDTH=2 still gets a real counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bundles the SPI pins and the parallel word port of the slave.
interface spi_slave_if #(
  parameter int WIDTH = spi_pkg::DEF_WIDTH
);

  logic             cs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output cs, mosi, tx_data,
    input  miso, rx_data, rx_valid
  );

  modport slave (
    input  cs, mosi, tx_data,
    output miso, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave.sv
// SPI slave clocked by clk: shifts MSB-first while cs is low and presents each
// completed word on rx_data with a one-cycle rx_valid pulse.
//
// state | meaning
// IDLE  | cs high: shreg preloads tx_data, counter cleared
// SHIFT | cs low: one bit per edge, last bit reloads tx_data and wraps
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_WORD = DEF_RESET_WORD[WIDTH-1:0]
) (
  input  logic             cs,
  input  logic             clk,
  input  logic             mosi,
  output logic             miso,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  spi_state_t       state;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic             rx_valid_nxt;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= RESET_WORD;
      cnt      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  // The mode is fully determined by cs; no separate state flop is kept.
  always_comb begin
    state        = cs ? IDLE : SHIFT;
    shifted      = {shreg[WIDTH-2:0], mosi};
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        shreg_nxt = tx_data;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          rx_data_nxt  = shifted;
          rx_valid_nxt = 1'b1;
          shreg_nxt    = tx_data;
          cnt_nxt      = '0;
        end else begin
          shreg_nxt = shifted;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      default: begin
        shreg_nxt = tx_data;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign miso = shreg[WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: reset, load, receive, back-to-back, abort and
// mid-frame reset, each against hand-computed words.
module tb_spi_slave;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_slave_if #(.WIDTH(8)) bus ();

  spi_slave #(.WIDTH(8), .RESET_WORD(8'h00)) dut (
    .cs       (bus.cs),
    .clk      (clk),
    .mosi     (bus.mosi),
    .miso     (bus.miso),
    .rst      (rst),
    .tx_data  (bus.tx_data),
    .rx_data  (bus.rx_data),
    .rx_valid (bus.rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one 8-bit frame with cs low; txw is the word expected on miso.
  task automatic run_frame(input string tag, input logic [7:0] word, input logic [7:0] txw);
    for (int i = 0; i < 8; i++) begin
      bus.cs   = 1'b0;
      bus.mosi = word[7-i];
      chk({tag, "_miso"}, 32'(bus.miso), 32'(txw[7-i]));
      tick();
      chk({tag, "_valid"}, 32'(bus.rx_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    chk({tag, "_data"}, 32'(bus.rx_data), 32'(word));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;
    tick();
    tick();
    chk("rst_miso", 32'(bus.miso), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    rst = 1'b0;

    // Load: one idle edge preloads tx_data, then shift it out with mosi low.
    bus.tx_data = 8'hA5;
    tick();
    chk("load_miso", 32'(bus.miso), 32'd1);
    run_frame("load", 8'h00, 8'hA5);
    bus.cs = 1'b1;
    tick();
    chk("load_idle_valid", 32'(bus.rx_valid), 32'd0);

    run_frame("rx_ca", 8'hCA, 8'hA5);
    bus.cs = 1'b1;
    tick();
    chk("rx_ca_pulse_end", 32'(bus.rx_valid), 32'd0);
    chk("rx_ca_hold", 32'(bus.rx_data), 32'hCA);

    // Back-to-back: no idle edge between the two frames.
    run_frame("b2b_3c", 8'h3C, 8'hA5);
    run_frame("b2b_f0", 8'hF0, 8'hA5);
    bus.cs = 1'b1;
    tick();
    chk("b2b_pulse_end", 32'(bus.rx_valid), 32'd0);

    // Abort after three bits.
    for (int i = 0; i < 3; i++) begin
      bus.cs   = 1'b0;
      bus.mosi = 1'b1;
      tick();
      chk("abort_valid", 32'(bus.rx_valid), 32'd0);
    end
    bus.cs = 1'b1;
    tick();
    chk("abort_idle_valid", 32'(bus.rx_valid), 32'd0);
    chk("abort_hold", 32'(bus.rx_data), 32'hF0);
    run_frame("after_abort", 8'h81, 8'hA5);
    bus.cs = 1'b1;
    tick();

    // Reset asserted between edges after four shift cycles.
    for (int i = 0; i < 4; i++) begin
      bus.cs   = 1'b0;
      bus.mosi = 1'b1;
      tick();
      chk("pre_rst_valid", 32'(bus.rx_valid), 32'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 32'(dut.cnt), 32'd0);
    chk("mid_rst_miso", 32'(bus.miso), 32'd0);
    chk("mid_rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // cs stays low through reset release, so the reset word (0) is shifted out.
    run_frame("after_rst", 8'h5A, 8'h00);
    bus.cs = 1'b1;
    tick();
    chk("final_valid", 32'(bus.rx_valid), 32'd0);
    chk("final_hold", 32'(bus.rx_data), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits (legal 2..32).
REQ-002 Parameter RESET_WORD, default 8'h00, shift-register value after reset (WIDTH bits).
REQ-003 The clock and reset ports SHALL be: one clock, clk; reset is asynchronous and active-high, named rst.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cs  input  1  active-low chip select/shift enable, synchronous to clk.
REQ-007 mosi  input  1  serial data from master, sampled on clk rising edge while cs low.
REQ-008 miso  output  1  serial data to master, MSB first.
REQ-009 tx_data  input  WIDTH  next word to transmit.
REQ-010 rx_data  output  WIDTH  last complete received word.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 Positional port order SHALL be cs, clk, mosi, miso, rst, tx_data, rx_data, rx_valid, so that a 4-port positional instance (cs, clk, mosi, miso) still connects correctly.

Function
REQ-013 State: shift register shreg[WIDTH-1:0], bit counter cnt of width clog2(WIDTH), rx_data register, rx_valid register.
REQ-014 miso SHALL equal shreg[WIDTH-1] continuously (registered source, no combinational path from mosi).
REQ-015 Idle (cs=1 at clk edge): shreg <= tx_data; cnt <= 0; rx_valid <= 0.
REQ-016 Shift (cs=0 at clk edge, cnt<WIDTH-1): shreg <= {shreg[WIDTH-2:0], mosi}; cnt <= cnt+1; rx_valid <= 0.
REQ-017 Last bit (cs=0, cnt==WIDTH-1): rx_data <= {shreg[WIDTH-2:0], mosi}; rx_valid <= 1; shreg <= tx_data; cnt <= 0, wrapping for back-to-back frames.
REQ-018 Latency: rx_valid SHALL assert in the cycle after the edge that samples the WIDTH-th bit, and SHALL last exactly one cycle.
REQ-019 cs deasserted mid-frame: the partial frame SHALL be discarded, rx_data held, and no rx_valid pulse issued; the next frame SHALL start at cnt=0.
REQ-020 cs held low continuously SHALL produce one rx_valid every WIDTH cycles with no gap bits.
REQ-021 tx_data SHALL be sampled only on idle edges or last-bit edges, never mid-frame.
REQ-022 Interface FSM states: IDLE (cs=1) and SHIFT (cs=0), implied by cs and cnt; no other states.

Reset
REQ-023 While rst=1: shreg=RESET_WORD, cnt=0, rx_data=0, rx_valid=0, so miso=RESET_WORD[WIDTH-1] (0 by default).
REQ-024 rst SHALL take effect immediately (asynchronously), and deassertion SHALL resume in IDLE/SHIFT per cs at the next edge; reset mid-frame SHALL discard the frame.

Structure
REQ-025 Counter-width function and default WIDTH/RESET_WORD SHALL live in a shared package spi_pkg.
REQ-026 Single module, no sub-modules; optional sub-module spi_shift_reg (shreg + cnt) is permitted.

Verification
REQ-027 Reset: assert rst with cs=1 -> miso=0, rx_data=8'h00, rx_valid=0.
REQ-028 Load: tx_data=8'hA5, cs=1 for 1 cycle -> miso=1; after 8 cs-low cycles the bits seen on miso before each edge are 1,0,1,0,0,1,0,1.
REQ-029 Receive: cs=0 for 8 cycles with mosi=1,1,0,0,1,0,1,0 -> rx_data=8'hCA and rx_valid high for exactly one cycle.
REQ-030 Back-to-back: cs low for 16 cycles with mosi streaming 8'h3C then 8'hF0 -> two rx_valid pulses 8 cycles apart with rx_data 8'h3C then 8'hF0.
REQ-031 Abort: cs low for 3 cycles, then high -> no rx_valid, rx_data unchanged, and the next full frame of 8'h81 is received correctly.
REQ-032 Reset mid-frame: pulse rst after 4 shift cycles -> cnt=0, rx_valid=0, and the following 8-bit frame is received intact.
